// File: rtl/agc_measure.sv
// AGC cycle sequencer and measurement stage: tick, accumulate window, settle, capture, serial sqrt.
// Optional macro AGC_MEASURE_AUTORESTART_EN chains cycles back-to-back while enable_i stays high.
module agc_measure #(
   parameter int SQ_BITS     = 24,
   parameter int PR_BITS     = 21,
   parameter int PERIOD_LOG2 = 17,
   parameter int SETTLE      = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               start_i,
   output logic               agc_tick_o,
   output logic               agc_ce_o,
   output logic               busy_o,
   input  logic [SQ_BITS-1:0] sq_accum_i,
   input  logic [PR_BITS-1:0] gt_accum_i,
   input  logic [PR_BITS-1:0] lt_accum_i,
   output logic [SQ_BITS/2-1:0] rms_o,
   output logic [PR_BITS-1:0] gt_o,
   output logic [PR_BITS-1:0] lt_o,
   output logic               valid_o
);

   localparam int HALF    = SQ_BITS / 2;
   localparam int AUX_MAX = (SETTLE > HALF) ? SETTLE : HALF;
   localparam int AUX_W   = $clog2(AUX_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TICK, S_ACCUM, S_SETTLE, S_CAPTURE, S_SQRT, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [PERIOD_LOG2-1:0] per_q, per_d;
   logic [AUX_W-1:0]       aux_q, aux_d;
   logic [SQ_BITS-1:0]     rad_q, rad_d;
   logic [HALF+1:0]        rem_q, rem_d;
   logic [HALF-1:0]        root_q, root_d;
   logic [HALF-1:0]        rms_q, rms_d;
   logic [PR_BITS-1:0]     gt_cap_q, gt_cap_d, lt_cap_q, lt_cap_d;
   logic [PR_BITS-1:0]     gt_q, gt_d, lt_q, lt_d;
   logic [HALF+3:0]        trial_lhs, trial_rhs, trial;
   logic                   trial_ok;
   logic [HALF-1:0]        root_next;
   logic                   tick, ce, valid;

   // Restoring step: bring down two radicand bits, try subtracting 4*root+1.
   assign trial_lhs = {rem_q, rad_q[SQ_BITS-1 -: 2]};
   assign trial_rhs = {2'b00, root_q, 2'b01};
   assign trial     = trial_lhs - trial_rhs;
   assign trial_ok  = (trial_lhs >= trial_rhs);
   assign root_next = {root_q[HALF-2:0], trial_ok};

   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      aux_d    = aux_q;
      rad_d    = rad_q;
      rem_d    = rem_q;
      root_d   = root_q;
      rms_d    = rms_q;
      gt_cap_d = gt_cap_q;
      lt_cap_d = lt_cap_q;
      gt_d     = gt_q;
      lt_d     = lt_q;
      tick     = 1'b0;
      ce       = 1'b0;
      valid    = 1'b0;
      case (state_q)
         S_IDLE: begin
            per_d = '0;
            aux_d = '0;
            if (start_i && enable_i) state_d = S_TICK;
         end
         S_TICK: begin
            tick    = 1'b1;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            ce    = 1'b1;
            per_d = per_q + PERIOD_LOG2'(1);
            if (per_q == '1) state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
         end
         S_SETTLE: begin
            aux_d = aux_q + AUX_W'(1);
            if (aux_q == AUX_W'(SETTLE - 1)) begin
               aux_d   = '0;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            rad_d    = sq_accum_i;
            rem_d    = '0;
            root_d   = '0;
            gt_cap_d = gt_accum_i;
            lt_cap_d = lt_accum_i;
            aux_d    = '0;
            state_d  = S_SQRT;
         end
         S_SQRT: begin
            rad_d  = rad_q << 2;
            root_d = root_next;
            rem_d  = trial_ok ? trial[HALF+1:0] : trial_lhs[HALF+1:0];
            aux_d  = aux_q + AUX_W'(1);
            if (aux_q == AUX_W'(HALF - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            valid = 1'b1;
            aux_d = '0;
            per_d = '0;
`ifdef AGC_MEASURE_AUTORESTART_EN
            // The DONE cycle doubles as the tick of the next cycle.
            if (enable_i) begin
               tick    = 1'b1;
               state_d = S_ACCUM;
            end else begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (!enable_i && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;

      // Results publish together, only when a cycle actually reaches DONE.
      if (state_q == S_SQRT && state_d == S_DONE) begin
         rms_d = root_next;
         gt_d  = gt_cap_q;
         lt_d  = lt_cap_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         per_q    <= '0;
         aux_q    <= '0;
         rad_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         rms_q    <= '0;
         gt_cap_q <= '0;
         lt_cap_q <= '0;
         gt_q     <= '0;
         lt_q     <= '0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         aux_q    <= aux_d;
         rad_q    <= rad_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         rms_q    <= rms_d;
         gt_cap_q <= gt_cap_d;
         lt_cap_q <= lt_cap_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
      end
   end

   assign agc_tick_o = tick;
   assign agc_ce_o   = ce;
   assign valid_o    = valid;
   assign busy_o     = (state_q != S_IDLE);
   assign rms_o      = rms_q;
   assign gt_o       = gt_q;
   assign lt_o       = lt_q;

endmodule
